// File: rtl/bios_pkg.sv
// Shared types for the BIOS/CPU RAM arbiter: FSM states, read-return owner tags
// and the bundled requester port.
package bios_pkg;

    localparam int REQ_ADDR_MSB = 31;
    localparam int REQ_DATA_MSB = 31;

    typedef enum logic {
        ST_BIOS,
        ST_SHARED
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_B,
        OWN_C
    } arb_owner_t;

    typedef struct packed {
        logic                    we;
        logic [3:0]              be;
        logic [REQ_ADDR_MSB:0]   addr;
        logic [REQ_DATA_MSB:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/ram_arbiter.sv
// Purpose: shares one RAM port between the BIOS loader (B) and the CPU (C); CPU priority after boot.
// Latency: grants and RAM strobes are combinational; read data returns 1 cycle after a read grant.
// Backpressure: requesters hold req with stable fields until gnt; clk_en=0 stalls grants, not returns.
module ram_arbiter
    import bios_pkg::*;
#(
    parameter int ADDR_WIDTH = REQ_ADDR_MSB,
    parameter int DATA_WIDTH = REQ_DATA_MSB,
    parameter int MAX_HOLD   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_booted,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic [3:0]            i_b_be,
    input  logic [ADDR_WIDTH:0]   i_b_addr,
    input  logic [DATA_WIDTH:0]   i_b_wdata,
    input  logic                  i_c_req,
    input  logic                  i_c_we,
    input  logic [3:0]            i_c_be,
    input  logic [ADDR_WIDTH:0]   i_c_addr,
    input  logic [DATA_WIDTH:0]   i_c_wdata,
    output logic                  o_b_gnt,
    output logic                  o_c_gnt,
    output logic                  o_b_rvalid,
    output logic                  o_c_rvalid,
    output logic [DATA_WIDTH:0]   o_b_rdata,
    output logic [DATA_WIDTH:0]   o_c_rdata,
    output logic                  o_read_req,
    output logic [ADDR_WIDTH:0]   o_read_addr,
    input  logic [DATA_WIDTH:0]   i_read_data,
    output logic                  o_write_enable,
    output logic [3:0]            o_byte_enable,
    output logic [ADDR_WIDTH:0]   o_write_addr,
    output logic [DATA_WIDTH:0]   o_write_data
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    arb_state_t state, state_nxt;
    arb_owner_t rsp_owner, rsp_owner_nxt;
    logic [7:0] hold_cnt;
    mem_req_t   b_bus, c_bus, win;
    logic       b_gnt, c_gnt, any_gnt;

    assign b_bus = '{we: i_b_we, be: i_b_be, addr: i_b_addr, wdata: i_b_wdata};
    assign c_bus = '{we: i_c_we, be: i_c_be, addr: i_c_addr, wdata: i_c_wdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_BIOS;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clk_en) begin
            unique case (state)
                ST_BIOS:   if (i_booted)  state_nxt = ST_SHARED;
                ST_SHARED: if (!i_booted) state_nxt = ST_BIOS;
                default:   state_nxt = ST_BIOS;
            endcase
        end
    end

    // CPU wins contention until BIOS has watched MAX_HOLD consecutive CPU grants.
    always_comb begin
        b_gnt = 1'b0;
        c_gnt = 1'b0;
        if (!rst && clk_en) begin
            unique case (state)
                ST_BIOS: b_gnt = i_b_req;
                ST_SHARED: begin
                    if (i_b_req && i_c_req) begin
                        if (hold_cnt == HOLD_LIM) b_gnt = 1'b1;
                        else                      c_gnt = 1'b1;
                    end else begin
                        b_gnt = i_b_req;
                        c_gnt = i_c_req;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_b_gnt = b_gnt;
    assign o_c_gnt = c_gnt;
    assign any_gnt = b_gnt | c_gnt;
    assign win     = b_gnt ? b_bus : c_bus;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (clk_en) begin
            if (b_gnt || !i_b_req)
                hold_cnt <= '0;
            else if (c_gnt && hold_cnt != HOLD_LIM)
                hold_cnt <= hold_cnt + 8'd1;
        end
    end

    always_comb begin
        o_write_enable = 1'b0;
        o_byte_enable  = '0;
        o_write_addr   = '0;
        o_write_data   = '0;
        o_read_req     = 1'b0;
        o_read_addr    = '0;
        if (any_gnt) begin
            if (win.we) begin
                o_write_enable = 1'b1;
                o_byte_enable  = win.be;
                o_write_addr   = win.addr;
                o_write_data   = win.wdata;
            end else begin
                o_read_req  = 1'b1;
                o_read_addr = win.addr;
            end
        end
    end

    // Return tag ignores clk_en so a read granted just before a stall still completes.
    always_comb begin
        rsp_owner_nxt = OWN_NONE;
        if (any_gnt && !win.we)
            rsp_owner_nxt = b_gnt ? OWN_B : OWN_C;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rsp_owner <= OWN_NONE;
        else     rsp_owner <= rsp_owner_nxt;
    end

    assign o_b_rvalid = (rsp_owner == OWN_B);
    assign o_c_rvalid = (rsp_owner == OWN_C);
    assign o_b_rdata  = o_b_rvalid ? i_read_data : '0;
    assign o_c_rdata  = o_c_rvalid ? i_read_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized + scenario-driven bench for ram_arbiter: an abstract grant/memory model pushes
// expected read returns into a queue that an independent monitor drains.
module tb_ram_arbiter;

    localparam int MAX_HOLD = 8;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } tb_req_t;

    typedef struct {
        int          owner;   // 1 = B, 2 = C
        logic [31:0] data;
        int          due;
    } rsp_t;

    logic        clk, rst, clk_en, i_booted;
    logic        i_b_req, i_b_we, i_c_req, i_c_we;
    logic [3:0]  i_b_be, i_c_be;
    logic [31:0] i_b_addr, i_b_wdata, i_c_addr, i_c_wdata;
    logic        o_b_gnt, o_c_gnt, o_b_rvalid, o_c_rvalid;
    logic [31:0] o_b_rdata, o_c_rdata;
    logic        o_read_req, o_write_enable;
    logic [31:0] o_read_addr, o_write_addr, o_write_data, i_read_data;
    logic [3:0]  o_byte_enable;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: boot flag as seen by the arbiter, and the run of CPU wins while BIOS waits.
    bit   booted_eff = 0;
    int   streak = 0;
    bit   m_b_gnt = 0, m_c_gnt = 0;
    rsp_t expq[$];

    bit      b_pend = 0, c_pend = 0;
    tb_req_t b_r, c_r;

    logic [31:0] ram     [64];
    logic [31:0] ref_mem [64];

    ram_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_booted(i_booted),
        .i_b_req(i_b_req), .i_b_we(i_b_we), .i_b_be(i_b_be), .i_b_addr(i_b_addr), .i_b_wdata(i_b_wdata),
        .i_c_req(i_c_req), .i_c_we(i_c_we), .i_c_be(i_c_be), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
        .o_b_gnt(o_b_gnt), .o_c_gnt(o_c_gnt), .o_b_rvalid(o_b_rvalid), .o_c_rvalid(o_c_rvalid),
        .o_b_rdata(o_b_rdata), .o_c_rdata(o_c_rdata),
        .o_read_req(o_read_req), .o_read_addr(o_read_addr), .i_read_data(i_read_data),
        .o_write_enable(o_write_enable), .o_byte_enable(o_byte_enable),
        .o_write_addr(o_write_addr), .o_write_data(o_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sequential RAM behind the arbiter.
    always @(posedge clk) begin
        if (o_write_enable)
            for (int k = 0; k < 4; k++)
                if (o_byte_enable[k]) ram[o_write_addr[5:0]][8*k +: 8] <= o_write_data[8*k +: 8];
        if (o_read_req)
            i_read_data <= ram[o_read_addr[5:0]];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : scoreboard
        logic eb, ec, ewe, ere;
        logic [3:0] ebe;
        logic [31:0] ewa, ewd, era;
        tb_req_t w;
        eb = 0; ec = 0; ewe = 0; ere = 0; ebe = 0; ewa = 0; ewd = 0; era = 0;
        if (rst) begin
            booted_eff = 0;
            streak = 0;
            expq.delete();
        end else if (clk_en) begin
            if (!booted_eff)            eb = i_b_req;
            else if (i_b_req && i_c_req) begin
                if (streak >= MAX_HOLD) eb = 1;
                else                    ec = 1;
            end else begin
                eb = i_b_req;
                ec = i_c_req;
            end
        end
        chk("grant", {o_b_gnt, o_c_gnt}, {eb, ec});
        if (eb) w = '{i_b_we, i_b_be, i_b_addr, i_b_wdata};
        else    w = '{i_c_we, i_c_be, i_c_addr, i_c_wdata};
        if (eb || ec) begin
            if (w.we) begin
                ewe = 1; ebe = w.be; ewa = w.addr; ewd = w.wdata;
                for (int k = 0; k < 4; k++)
                    if (w.be[k]) ref_mem[w.addr[5:0]][8*k +: 8] = w.wdata[8*k +: 8];
            end else begin
                ere = 1; era = w.addr;
                expq.push_back('{eb ? 1 : 2, ref_mem[w.addr[5:0]], cyc + 1});
            end
        end
        chk("ram_ctl", {o_write_enable, o_read_req, o_byte_enable}, {ewe, ere, ebe});
        chk("ram_bus", {o_write_addr, o_write_data, o_read_addr}, {ewa, ewd, era});
        if (!rst && clk_en) begin
            if (eb || !i_b_req) streak = 0;
            else if (ec)        streak++;
            booted_eff = i_booted;
        end
        m_b_gnt = eb;
        m_c_gnt = ec;
    end

    always @(negedge clk) begin : monitor
        rsp_t e;
        chk("rvalid_excl", o_b_rvalid & o_c_rvalid, 0);
        if (o_b_rvalid || o_c_rvalid) begin
            if (expq.size() == 0) begin
                chk("rsp_unexpected", {o_b_rvalid, o_c_rvalid}, 2'b00);
            end else begin
                e = expq.pop_front();
                chk("rsp_owner", {o_b_rvalid, o_c_rvalid}, (e.owner == 1) ? 2'b10 : 2'b01);
                chk("rsp_data", o_b_rvalid ? o_b_rdata : o_c_rdata, e.data);
                chk("rsp_other_zero", o_b_rvalid ? o_c_rdata : o_b_rdata, 0);
                chk("rsp_cycle", cyc, e.due);
            end
        end else if (expq.size() > 0 && expq[0].due <= cyc) begin
            e = expq.pop_front();
            chk("rsp_missing", {o_b_rvalid, o_c_rvalid}, (e.owner == 1) ? 2'b10 : 2'b01);
        end
    end

    function automatic tb_req_t rnd_req();
        tb_req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.be    = 4'($urandom_range(0, 15));
        r.addr  = 32'($urandom_range(0, 63));
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic tb_req_t mk(input logic we, input logic [3:0] be,
                                   input logic [31:0] a, input logic [31:0] d);
        tb_req_t r;
        r.we = we; r.be = be; r.addr = a; r.wdata = d;
        return r;
    endfunction

    task automatic apply();
        i_b_req = b_pend; i_b_we = b_r.we; i_b_be = b_r.be; i_b_addr = b_r.addr; i_b_wdata = b_r.wdata;
        i_c_req = c_pend; i_c_we = c_r.we; i_c_be = c_r.be; i_c_addr = c_r.addr; i_c_wdata = c_r.wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (m_b_gnt) b_pend = 0;
        if (m_c_gnt) c_pend = 0;
    endtask

    task automatic step();
        apply();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]     = 32'h5A00_0000 + 32'(i);
            ref_mem[i] = 32'h5A00_0000 + 32'(i);
        end
        ram[4] = 32'h1111_1111; ref_mem[4] = 32'h1111_1111;
        ram[8] = 32'h2222_2222; ref_mem[8] = 32'h2222_2222;
        i_read_data = 0;
        b_r = mk(0, 0, 0, 0);
        c_r = mk(0, 0, 0, 0);
        rst = 1; clk_en = 1; i_booted = 0;
        apply();
        #2;
        chk("reset_outputs", {o_b_gnt, o_c_gnt, o_b_rvalid, o_c_rvalid, o_read_req, o_write_enable,
                              o_byte_enable, o_read_addr, o_write_addr, o_write_data},
            0);
        chk("reset_rdata", {o_b_rdata, o_c_rdata}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // Pre-boot: CPU stalls while BIOS writes, then the CPU read sees the BIOS data.
        c_r = mk(0, 4'hF, 32'h10, 0);              c_pend = 1;
        b_r = mk(1, 4'hF, 32'h10, 32'hDEAD_BEEF);  b_pend = 1;
        for (int i = 0; i < 20; i++) step();
        i_booted = 1;
        for (int i = 0; i < 4; i++) step();

        // Sustained contention exercises the starvation guarantee.
        for (int i = 0; i < 40; i++) begin
            if (!b_pend) begin b_r = rnd_req(); b_pend = 1; end
            if (!c_pend) begin c_r = rnd_req(); c_pend = 1; end
            step();
        end
        b_pend = 0; c_pend = 0;
        step(); step();

        // Read routing on consecutive cycles.
        b_r = mk(0, 0, 32'h4, 0); b_pend = 1; step();
        c_r = mk(0, 0, 32'h8, 0); c_pend = 1; step();
        step(); step();

        // Stall right after a CPU read grant with both sides pending.
        c_r = mk(0, 0, 32'h8, 0); c_pend = 1; step();
        b_r = mk(0, 0, 32'h4, 0); b_pend = 1;
        c_r = mk(1, 4'hF, 32'h30, 32'h1234_5678); c_pend = 1;
        clk_en = 0;
        for (int i = 0; i < 3; i++) step();
        clk_en = 1;
        for (int i = 0; i < 4; i++) step();

        // Byte-enabled CPU write, then read it back.
        c_r = mk(1, 4'b0100, 32'h20, 32'hAABB_CCDD); c_pend = 1; step();
        c_r = mk(0, 0, 32'h20, 0); c_pend = 1; step();
        step(); step();

        // Async reset between a read grant and its return edge.
        b_pend = 0;
        c_r = mk(0, 0, 32'h8, 0); c_pend = 1;
        apply();
        @(negedge clk); #2;
        rst = 1;
        expq.delete();
        #1;
        chk("rst_mid_gnt", {o_b_gnt, o_c_gnt}, 0);
        chk("rst_mid_ram", {o_read_req, o_write_enable, o_byte_enable, o_read_addr}, 0);
        chk("rst_mid_rvalid", {o_b_rvalid, o_c_rvalid}, 0);
        b_pend = 0; c_pend = 0; apply();
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        c_r = mk(0, 0, 32'h8, 0); c_pend = 1;
        for (int i = 0; i < 4; i++) step();

        // Randomized traffic with stalls and boot-flag flips.
        for (int i = 0; i < 600; i++) begin
            if (!b_pend && $urandom_range(0, 2) == 0) begin b_r = rnd_req(); b_pend = 1; end
            if (!c_pend && $urandom_range(0, 2) == 0) begin c_r = rnd_req(); c_pend = 1; end
            clk_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 29) == 0) i_booted = ~i_booted;
            step();
        end

        b_pend = 0; c_pend = 0; clk_en = 1;
        for (int i = 0; i < 4; i++) step();
        chk("queue_drained", 128'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
